// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control/status bundle between the multi-cycle controller (master) and datapath/memory (slave)
interface multicycle_control_if #(parameter int ALU_CTRL_W = 4);
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7_5;
  logic alu_zero;
  logic mem_ready;
  logic mem_req;
  logic mem_wen;
  logic adr_src;
  logic ir_wen;
  logic pc_wen;
  logic reg_wen;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [2:0] result_src;
  logic illegal;
  logic fault;
  logic [3:0] state;
  modport master (
    input op, funct3, funct7_5, alu_zero, mem_ready,
    output mem_req, mem_wen, adr_src, ir_wen, pc_wen, reg_wen, alu_src_a, alu_src_b,
    output alu_control, result_src, illegal, fault, state
  );
  modport slave (
    output op, funct3, funct7_5, alu_zero, mem_ready,
    input mem_req, mem_wen, adr_src, ir_wen, pc_wen, reg_wen, alu_src_a, alu_src_b,
    input alu_control, result_src, illegal, fault, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I control FSM sharing one ALU and one memory port,
// with sticky illegal-opcode and memory-timeout faults.
module multicycle_control #(
  parameter int ALU_CTRL_W = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, MEM_ADDR = 4'd4,
    MEM_RD = 4'd5, MEM_WB = 4'd6, MEM_WR = 4'd7, ALU_WB = 4'd8, BRANCH = 4'd9,
    JAL = 4'd10, JALR = 4'd11, LUI = 4'd12, HALT = 4'd15
  } state_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_REG = 7'b0110011,
    OP_IMM = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  state_t st, nxt;
  logic [7:0] cnt;
  logic wait_mem, tmo, bad, ill_q, flt_q;
  logic [3:0] alu;
  logic [3:0] bcode;
  logic [2:0] f3;
  assign f3 = bus.funct3;
  // Branch compares fill the six codes left free by the {funct7_5, funct3} ALU ops
  assign bcode = f3 == 3'b000 ? 4'b1001 : f3 == 3'b001 ? 4'b1010 : f3 == 3'b101 ? 4'b1011 : {1'b1, f3};
  assign bus.mem_req = st == FETCH || st == MEM_RD || st == MEM_WR;
  assign wait_mem = bus.mem_req && !bus.mem_ready;
  assign tmo = wait_mem && cnt == 8'(MEM_TIMEOUT - 1);
  assign bus.alu_control = ALU_CTRL_W'(alu);
  assign bus.state = st;
  assign bus.illegal = ill_q;
  assign bus.fault = flt_q;
  always_comb begin
    nxt = st;
    bad = 1'b0;
    alu = 4'd0;
    bus.mem_wen = 1'b0;
    bus.adr_src = 1'b0;
    bus.ir_wen = 1'b0;
    bus.pc_wen = 1'b0;
    bus.reg_wen = 1'b0;
    bus.alu_src_a = 2'd0;
    bus.alu_src_b = 2'd0;
    bus.result_src = 3'd0;
    case (st)
      FETCH: begin
        bus.alu_src_b = 2'd2;
        bus.ir_wen = bus.mem_ready;
        bus.pc_wen = bus.mem_ready;
        nxt = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_a = 2'd1;
        bus.alu_src_b = 2'd1;
        case (bus.op)
          OP_LOAD, OP_STORE: nxt = MEM_ADDR;
          OP_REG: nxt = EXEC_R;
          OP_IMM: nxt = EXEC_I;
          OP_BRANCH: nxt = BRANCH;
          OP_JAL: nxt = JAL;
          OP_JALR: nxt = JALR;
          OP_LUI: nxt = LUI;
          OP_AUIPC: nxt = ALU_WB;
          default: begin
            bad = 1'b1;
            nxt = HALT;
          end
        endcase
      end
      EXEC_R: begin
        bus.alu_src_a = 2'd2;
        alu = {bus.funct7_5 && (f3 == 3'b000 || f3 == 3'b101), f3};
        nxt = ALU_WB;
      end
      EXEC_I: begin
        bus.alu_src_a = 2'd2;
        bus.alu_src_b = 2'd1;
        alu = {bus.funct7_5 && f3 == 3'b101, f3};
        nxt = ALU_WB;
      end
      ALU_WB, MEM_WB: begin
        bus.result_src = st == ALU_WB ? 3'd2 : 3'd3;
        bus.reg_wen = 1'b1;
        nxt = FETCH;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 2'd2;
        bus.alu_src_b = 2'd1;
        nxt = bus.op[5] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.adr_src = 1'b1;
        nxt = bus.mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WR: begin
        bus.adr_src = 1'b1;
        bus.mem_wen = 1'b1;
        nxt = bus.mem_ready ? FETCH : MEM_WR;
      end
      BRANCH: begin
        bus.alu_src_a = 2'd2;
        bus.result_src = 3'd2;
        alu = bcode;
        bad = f3[2:1] == 2'b01;
        bus.pc_wen = bus.alu_zero && !bad;
        nxt = bad ? HALT : FETCH;
      end
      JAL, JALR: begin
        bus.alu_src_a = st == JAL ? 2'd1 : 2'd2;
        bus.alu_src_b = st == JAL ? 2'd2 : 2'd1;
        bus.reg_wen = 1'b1;
        bus.pc_wen = 1'b1;
        nxt = FETCH;
      end
      LUI: begin
        bus.result_src = 3'd1;
        bus.reg_wen = 1'b1;
        nxt = FETCH;
      end
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= FETCH;
      cnt <= '0;
      ill_q <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      st <= tmo ? HALT : nxt;
      cnt <= wait_mem ? cnt + 8'd1 : 8'd0;
      ill_q <= ill_q || bad;
      flt_q <= flt_q || tmo;
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream with a reactive memory, checked against
// an instruction-level model of latency, write-enable counts and ALU function.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, REGOP = 7'b0110011,
    IMM = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
    LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam int A_ADD = 0, A_SUB = 8, A_SRA = 13;
  int base_alu[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int br_alu[8] = '{9, 10, -1, -1, 12, 11, 14, 15};
  logic [6:0] ops[9] = '{REGOP, IMM, AUIPC, LOAD, STORE, BR, JAL, JALR, LUI};
  logic [6:0] bad_ops[4] = '{7'b0001111, 7'b1110011, 7'b0000000, 7'b1111111};

  multicycle_control_if #(.ALU_CTRL_W(4)) bus ();
  multicycle_control #(.ALU_CTRL_W(4), .MEM_TIMEOUT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                           input int wf, input int wd);
    int cyc = 0, regs = 0, pcs = 0, mw = 0, rs = -1, alu = -1, waited = 0, target = wf;
    int e_cyc = 0, e_reg = 0, e_pc = 1, e_mw = 0, e_rs = -1, e_alu = A_ADD;
    bit e_ill = 0, done = 0, left = 0;
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7_5 = f7;
    bus.alu_zero = z;
    case (o)
      REGOP: begin
        e_cyc = 4 + wf; e_reg = 1; e_rs = 2;
        e_alu = (f7 && f3 == 3'd0) ? A_SUB : (f7 && f3 == 3'd5) ? A_SRA : base_alu[f3];
      end
      IMM: begin
        e_cyc = 4 + wf; e_reg = 1; e_rs = 2;
        e_alu = (f7 && f3 == 3'd5) ? A_SRA : base_alu[f3];
      end
      AUIPC: begin e_cyc = 4 + wf; e_reg = 1; e_rs = 2; end
      LOAD: begin e_cyc = 5 + wf + wd; e_reg = 1; e_rs = 3; end
      STORE: begin e_cyc = 4 + wf + wd; e_mw = wd + 1; end
      BR: begin
        e_cyc = 3 + wf;
        e_ill = f3 == 3'd2 || f3 == 3'd3;
        e_pc = 1 + int'(z && !e_ill);
        e_alu = br_alu[f3];
      end
      JAL, JALR: begin e_cyc = 3 + wf; e_reg = 1; e_pc = 2; e_rs = 0; end
      LUI: begin e_cyc = 3 + wf; e_reg = 1; e_rs = 1; end
      default: begin e_cyc = 2 + wf; e_ill = 1; e_alu = -1; end
    endcase
    for (int k = 0; k < 64 && !done; k++) begin
      if (left && (bus.state == 4'd0 || bus.state == 4'd15)) done = 1;
      else begin
        left = left || bus.state != 4'd0;
        bus.mem_ready = bus.mem_req ? (waited == target) : 1'($urandom);
        #1;
        if (bus.mem_req) begin
          if (bus.mem_ready) begin waited = 0; target = wd; end
          else waited++;
        end
        cyc++;
        if (bus.reg_wen) begin regs++; rs = int'(bus.result_src); end
        if (bus.pc_wen) pcs++;
        if (bus.mem_wen) mw++;
        if (alu < 0 && bus.state != 4'd0 && bus.state != 4'd1) alu = int'(bus.alu_control);
        @(negedge clk);
      end
    end
    check($sformatf("done op=%b", o), int'(done), 1);
    check($sformatf("cycles op=%b f3=%0d", o, f3), cyc, e_cyc);
    check($sformatf("reg_wen op=%b", o), regs, e_reg);
    check($sformatf("pc_wen op=%b z=%0d", o, z), pcs, e_pc);
    check($sformatf("mem_wen op=%b", o), mw, e_mw);
    check($sformatf("end_state op=%b", o), int'(bus.state), e_ill ? 15 : 0);
    check($sformatf("illegal op=%b", o), int'(bus.illegal), int'(e_ill));
    if (e_reg > 0) check($sformatf("result_src op=%b", o), rs, e_rs);
    if (!e_ill) check($sformatf("alu op=%b f3=%0d f7=%0d", o, f3, f7), alu, e_alu);
    if (e_ill) begin
      @(negedge clk);
      check("halt_mem_req", int'(bus.mem_req), 0);
      check("halt_state", int'(bus.state), 15);
      do_reset();
      check("rst_state", int'(bus.state), 0);
      check("rst_illegal", int'(bus.illegal), 0);
    end
  endtask

  initial begin
    bus.op = REGOP;
    bus.funct3 = 3'd0;
    bus.funct7_5 = 1'b0;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("rst_state0", int'(bus.state), 0);
    check("rst_mem_req", int'(bus.mem_req), 1);
    check("rst_adr_src", int'(bus.adr_src), 0);
    check("rst_wens", int'({bus.reg_wen, bus.pc_wen, bus.ir_wen, bus.mem_wen}), 0);
    check("rst_flags", int'({bus.illegal, bus.fault}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(REGOP, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(LOAD, 3'd2, 1'b0, 1'b0, 0, 3);
    run_instr(BR, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(BR, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0001111, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(BR, 3'd2, 1'b0, 1'b1, 1, 0);
    for (int i = 0; i < 60; i++) begin
      int sel = $urandom_range(0, 19);
      logic [6:0] o = sel < 18 ? ops[sel % 9] : bad_ops[$urandom_range(0, 3)];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    do_reset();
    bus.op = REGOP;
    repeat (14) @(negedge clk);
    check("tmo_14_state", int'(bus.state), 0);
    check("tmo_14_fault", int'(bus.fault), 0);
    @(negedge clk);
    check("tmo_15_fault", int'(bus.fault), 1);
    check("tmo_15_state", int'(bus.state), 15);
    check("tmo_mem_req", int'(bus.mem_req), 0);
    do_reset();
    check("tmo_rst_fault", int'(bus.fault), 0);
    repeat (14) @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("ready_wins_state", int'(bus.state), 1);
    check("ready_wins_fault", int'(bus.fault), 0);
    do_reset();
    bus.op = STORE;
    bus.funct3 = 3'd2;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 10 && bus.state != 4'd7; k++) @(negedge clk);
    check("reach_mem_wr", int'(bus.state), 7);
    bus.mem_ready = 1'b0;
    #1;
    check("mem_wr_wen", int'(bus.mem_wen), 1);
    rst_n = 1'b0;
    #1;
    check("async_mem_wen", int'(bus.mem_wen), 0);
    check("async_state", int'(bus.state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_state", int'(bus.state), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
